// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg : opcode map, instruction field positions and fetch FSM encoding
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package isa_pkg;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_STRI  = 4'b0100;
  localparam logic [3:0] OP_BOZ   = 4'b0110;
  localparam logic [3:0] OP_BRAN  = 4'b1000;
  localparam logic [3:0] OP_COMP  = 4'b1010;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OFF_MSB = 7;
  localparam int OFF_LSB = 0;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Odd opcodes are the ALU operations that write a register.
  function automatic logic is_alu_write(input logic [3:0] opc);
    return opc[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer : in-order current + prefetch register pair with push/pop/clear
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_buffer #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  input  logic               pop,
  input  logic               clear,
  output logic [INSTR_W-1:0] cur_instr,
  output logic [PC_W-1:0]    cur_pc,
  output logic               empty,
  output logic               full,
  output logic               full_next
);

  logic               cur_valid_q, cur_valid_d;
  logic [INSTR_W-1:0] cur_instr_q, cur_instr_d;
  logic [PC_W-1:0]    cur_pc_q, cur_pc_d;
  logic               pf_valid_q, pf_valid_d;
  logic [INSTR_W-1:0] pf_instr_q, pf_instr_d;
  logic [PC_W-1:0]    pf_pc_q, pf_pc_d;

  always_comb begin
    cur_valid_d = cur_valid_q;
    cur_instr_d = cur_instr_q;
    cur_pc_d    = cur_pc_q;
    pf_valid_d  = pf_valid_q;
    pf_instr_d  = pf_instr_q;
    pf_pc_d     = pf_pc_q;
    if (clear) begin
      cur_valid_d = 1'b0;
      pf_valid_d  = 1'b0;
    end else if (pop) begin
      // Older prefetched word moves up before any newly pushed word.
      if (pf_valid_q) begin
        cur_valid_d = 1'b1;
        cur_instr_d = pf_instr_q;
        cur_pc_d    = pf_pc_q;
        pf_valid_d  = push;
        if (push) begin
          pf_instr_d = push_instr;
          pf_pc_d    = push_pc;
        end
      end else begin
        cur_valid_d = push;
        if (push) begin
          cur_instr_d = push_instr;
          cur_pc_d    = push_pc;
        end
      end
    end else if (push) begin
      if (!cur_valid_q) begin
        cur_valid_d = 1'b1;
        cur_instr_d = push_instr;
        cur_pc_d    = push_pc;
      end else begin
        pf_valid_d = 1'b1;
        pf_instr_d = push_instr;
        pf_pc_d    = push_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_valid_q <= 1'b0;
      cur_instr_q <= '0;
      cur_pc_q    <= '0;
      pf_valid_q  <= 1'b0;
      pf_instr_q  <= '0;
      pf_pc_q     <= '0;
    end else begin
      cur_valid_q <= cur_valid_d;
      cur_instr_q <= cur_instr_d;
      cur_pc_q    <= cur_pc_d;
      pf_valid_q  <= pf_valid_d;
      pf_instr_q  <= pf_instr_d;
      pf_pc_q     <= pf_pc_d;
    end
  end

  assign cur_instr = cur_instr_q;
  assign cur_pc    = cur_pc_q;
  assign empty     = ~cur_valid_q;
  assign full      = cur_valid_q & pf_valid_q;
  assign full_next = cur_valid_d & pf_valid_d;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit : PC, fetch FSM and branch redirection feeding the decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               bra,
  input  logic               branch,
  input  logic               zero
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] redirect_q, redirect_d;
  logic            run_q, run_d;

  logic               buf_push, buf_pop, buf_clear;
  logic               buf_empty, buf_full, buf_full_next;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc;

  logic            ack_v, accept, taken;
  logic [PC_W-1:0] off_ext, target;

  fetch_buffer #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (buf_push),
    .push_instr (imem_rdata),
    .push_pc    (fetch_pc_q),
    .pop        (buf_pop),
    .clear      (buf_clear),
    .cur_instr  (buf_instr),
    .cur_pc     (buf_pc),
    .empty      (buf_empty),
    .full       (buf_full),
    .full_next  (buf_full_next)
  );

  assign instr_valid = ~buf_empty;
  assign instr       = buf_instr;
  assign opcode      = buf_instr[OPC_MSB:OPC_LSB];
  assign instr_pc    = buf_pc;

  assign accept  = instr_valid & instr_ready;
  assign taken   = accept & (bra | (branch & zero));
  assign ack_v   = imem_req & imem_ack;
  assign off_ext = PC_W'(signed'(buf_instr[OFF_MSB:OFF_LSB]));
  assign target  = buf_pc + PC_W'(1) + off_ext;

  // State register; run_q keeps imem_req low during and right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      redirect_q <= RESET_PC;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      redirect_q <= redirect_d;
      run_q      <= run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    redirect_d = redirect_q;
    run_d      = 1'b1;
    case (state_q)
      FETCH: begin
        if (taken) begin
          if (ack_v || !imem_req) begin
            fetch_pc_d = target;
          end else begin
            redirect_d = target;
            state_d    = FLUSH;
          end
        end else if (ack_v) begin
          fetch_pc_d = fetch_pc_q + PC_W'(1);
          if (buf_full_next) state_d = STALL;
        end
      end
      STALL: begin
        if (taken) begin
          fetch_pc_d = target;
          state_d    = FETCH;
        end else if (accept) begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        // The stale word is dropped; only then does the redirect take effect.
        if (ack_v) begin
          fetch_pc_d = redirect_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = run_q & (((state_q == FETCH) & ~buf_full) | (state_q == FLUSH));
    imem_addr = fetch_pc_q;
    buf_push  = ack_v & (state_q == FETCH) & ~taken;
    buf_pop   = accept;
    buf_clear = taken;
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  instr_pc;
  logic        bra;
  logic        branch;
  logic        zero;

  logic [15:0] mem [256];
  int          lat = 0;
  int          cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic        found;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .PC_W     (8),
    .RESET_PC (8'h00),
    .INSTR_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .bra         (bra),
    .branch      (branch),
    .zero        (zero)
  );

  // Memory responder: ack once a request has been held for lat cycles.
  always @(posedge clk) cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = mem[imem_addr];

  // Stand-in for the control decoder.
  assign bra    = instr_valid && (opcode == 4'b1000);
  assign branch = instr_valid && ((opcode == 4'b1000) || (opcode == 4'b0110));

  function automatic logic [15:0] plain_word(input logic [7:0] a);
    return {4'h2, 4'h0, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_until_pc(input logic [7:0] pc, input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (instr_valid && instr_pc == pc) found = 1'b1;
    end
    chk("reach_pc", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (instr_valid) found = 1'b1;
    end
    chk("wait_valid", {31'd0, found}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = plain_word(8'(a));
    mem[8'h10] = 16'h80FC;
    mem[8'h20] = 16'h6005;
    mem[8'hFF] = 16'h8001;
    rst = 1'b1;
    instr_ready = 1'b1;
    zero = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  {16'd0, instr}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_pc",     {24'd0, instr_pc}, 32'd0);

    // Streaming, same-cycle ack
    rst = 1'b0;
    step();
    chk("s_req0",   {31'd0, imem_req}, 32'd1);
    chk("s_addr0",  {24'd0, imem_addr}, 32'd0);
    chk("s_valid0", {31'd0, instr_valid}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("s_addr",  {24'd0, imem_addr}, 32'(k));
      chk("s_valid", {31'd0, instr_valid}, 32'd1);
      chk("s_pc",    {24'd0, instr_pc}, 32'(k - 1));
      chk("s_instr", {16'd0, instr}, {16'd0, plain_word(8'(k - 1))});
    end

    // Back-pressure for 5 cycles
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_req",   {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_pc",    {24'd0, instr_pc}, 32'd2);
      chk("bp_instr", {16'd0, instr}, {16'd0, plain_word(8'h02)});
    end
    instr_ready = 1'b1;
    step();
    chk("rel_pc3",   {24'd0, instr_pc}, 32'd3);
    chk("rel_req",   {31'd0, imem_req}, 32'd1);
    chk("rel_addr",  {24'd0, imem_addr}, 32'd4);
    step();
    chk("rel_valid", {31'd0, instr_valid}, 32'd1);
    chk("rel_pc4",   {24'd0, instr_pc}, 32'd4);

    // bran at 0x10, offset -4
    step_until_pc(8'h10, 40);
    chk("bran_opc", {28'd0, opcode}, 32'h8);
    step();
    chk("bran_bubble", {31'd0, instr_valid}, 32'd0);
    chk("bran_addr",   {24'd0, imem_addr}, 32'h0D);
    step();
    chk("bran_valid", {31'd0, instr_valid}, 32'd1);
    chk("bran_pc",    {24'd0, instr_pc}, 32'h0D);
    chk("bran_instr", {16'd0, instr}, {16'd0, plain_word(8'h0D)});
    step();
    chk("bran_next",  {24'd0, instr_pc}, 32'h0E);
    mem[8'h10] = plain_word(8'h10);

    // boz not taken
    step_until_pc(8'h20, 40);
    step();
    chk("boz_nt_valid", {31'd0, instr_valid}, 32'd1);
    chk("boz_nt_pc",    {24'd0, instr_pc}, 32'h21);

    // boz taken, offset +5
    zero = 1'b1;
    do_reset();
    chk("rst2_addr", {24'd0, imem_addr}, 32'd0);
    step_until_pc(8'h20, 60);
    step();
    chk("boz_t_bubble", {31'd0, instr_valid}, 32'd0);
    step();
    chk("boz_t_valid", {31'd0, instr_valid}, 32'd1);
    chk("boz_t_pc",    {24'd0, instr_pc}, 32'h26);
    zero = 1'b0;

    // FLUSH with latency-3 memory; target wraps 0xFF+1+1 -> 0x01
    step_until_pc(8'hFE, 300);
    lat = 3;
    step_until_pc(8'hFF, 12);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_req",   {31'd0, imem_req}, 32'd1);
      chk("fl_addr",  {24'd0, imem_addr}, 32'h00);
      chk("fl_valid", {31'd0, instr_valid}, 32'd0);
    end
    step();
    chk("fl_redir_addr", {24'd0, imem_addr}, 32'h01);
    chk("fl_redir_req",  {31'd0, imem_req}, 32'd1);
    wait_valid(12);
    chk("fl_pc",    {24'd0, instr_pc}, 32'h01);
    chk("fl_instr", {16'd0, instr}, {16'd0, plain_word(8'h01)});

    // Reset in the middle of FLUSH
    mem[8'h02] = 16'h8000;
    step_until_pc(8'h02, 12);
    step();
    chk("fl2_req",   {31'd0, imem_req}, 32'd1);
    chk("fl2_addr",  {24'd0, imem_addr}, 32'h03);
    chk("fl2_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b1;
    step();
    chk("rfl_req",   {31'd0, imem_req}, 32'd0);
    chk("rfl_valid", {31'd0, instr_valid}, 32'd0);
    chk("rfl_pc",    {24'd0, instr_pc}, 32'd0);
    chk("rfl_instr", {16'd0, instr}, 32'd0);
    rst = 1'b0;
    lat = 0;
    step();
    chk("rfl_req1",  {31'd0, imem_req}, 32'd1);
    chk("rfl_addr1", {24'd0, imem_addr}, 32'd0);
    step();
    chk("rfl_valid1", {31'd0, instr_valid}, 32'd1);
    chk("rfl_pc1",    {24'd0, instr_pc}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
